// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// register count and the requester-select type used for round-robin state.
package regfile_arb_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int NREG   = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two requester handshakes, the register-file write port and
// the read-address hazard lookup. The arbiter sits on the slave side.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
    parameter int DATA_W = regfile_arb_pkg::DATA_W
);

    logic                     A_VALID;
    logic                     A_READY;
    logic [ADDR_W-1:0]        A_ADDR;
    logic signed [DATA_W-1:0] A_DATA;

    logic                     B_VALID;
    logic                     B_READY;
    logic [ADDR_W-1:0]        B_ADDR;
    logic signed [DATA_W-1:0] B_DATA;

    logic                     WRITE;
    logic [ADDR_W-1:0]        INADDRESS;
    logic signed [DATA_W-1:0] IN;

    logic [ADDR_W-1:0]        RD1ADDR;
    logic [ADDR_W-1:0]        RD2ADDR;
    logic                     HAZARD1;
    logic                     HAZARD2;

    modport master (
        output A_VALID, A_ADDR, A_DATA,
        input  A_READY,
        output B_VALID, B_ADDR, B_DATA,
        input  B_READY,
        input  WRITE, INADDRESS, IN,
        output RD1ADDR, RD2ADDR,
        input  HAZARD1, HAZARD2
    );

    modport slave (
        input  A_VALID, A_ADDR, A_DATA,
        output A_READY,
        input  B_VALID, B_ADDR, B_DATA,
        output B_READY,
        output WRITE, INADDRESS, IN,
        input  RD1ADDR, RD2ADDR,
        output HAZARD1, HAZARD2
    );

endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small writeback queue: DEPTH entries of {address, data}, with a per-slot
// match vector against the two read addresses so the top can flag hazards
// on anything still waiting to be written.
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic signed [DATA_W-1:0] push_data,
    input  logic                     pop,
    output logic                     ready,
    output logic                     nonempty,
    output logic [ADDR_W-1:0]        head_addr,
    output logic signed [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0]        rd1addr,
    input  logic [ADDR_W-1:0]        rd2addr,
    output logic [DEPTH-1:0]         match1,
    output logic [DEPTH-1:0]         match2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W-1:0]        addr_mem [DEPTH];
    logic signed [DATA_W-1:0] data_mem [DEPTH];
    logic                     do_push;
    logic                     do_pop;
    logic [PTR_W-1:0]         off;

    // Ready depends only on occupancy (and reset), never on the requester's valid.
    assign ready     = !RESET && (count < CNT_W'(DEPTH));
    assign nonempty  = (count != '0);
    assign do_push   = push && ready;
    assign do_pop    = pop && nonempty && !RESET;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Pointers wrap naturally at DEPTH (power of two); simultaneous push/pop keeps count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage is pure datapath; stale contents are masked by occupancy.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        match1 = '0;
        match2 = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if ({1'b0, off} < count) begin
                match1[i] = (addr_mem[i] == rd1addr);
                match2[i] = (addr_mem[i] == rd2addr);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter. ALU and load writebacks each
// queue in a wb_fifo; one head per cycle is granted round-robin and
// registered onto the register-file write port. Hazard flags cover every
// queued entry plus the write currently being presented.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = regfile_arb_pkg::DATA_W,
    parameter int ADDR_W = regfile_arb_pkg::ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RESET,
    regfile_write_arbiter_if.slave bus
);

    logic                     a_ready, b_ready;
    logic                     a_ne, b_ne;
    logic                     grant_a, grant_b;
    logic [ADDR_W-1:0]        a_head_addr, b_head_addr;
    logic signed [DATA_W-1:0] a_head_data, b_head_data;
    logic [DEPTH-1:0]         a_m1, a_m2, b_m1, b_m2;
    port_sel_e                last;

    logic                     vld_p0;
    logic [ADDR_W-1:0]        addr_p0;
    logic signed [DATA_W-1:0] data_p0;

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo_a (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (bus.A_VALID),
        .push_addr (bus.A_ADDR),
        .push_data (bus.A_DATA),
        .pop       (grant_a),
        .ready     (a_ready),
        .nonempty  (a_ne),
        .head_addr (a_head_addr),
        .head_data (a_head_data),
        .rd1addr   (bus.RD1ADDR),
        .rd2addr   (bus.RD2ADDR),
        .match1    (a_m1),
        .match2    (a_m2)
    );

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo_b (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (bus.B_VALID),
        .push_addr (bus.B_ADDR),
        .push_data (bus.B_DATA),
        .pop       (grant_b),
        .ready     (b_ready),
        .nonempty  (b_ne),
        .head_addr (b_head_addr),
        .head_data (b_head_data),
        .rd1addr   (bus.RD1ADDR),
        .rd2addr   (bus.RD2ADDR),
        .match1    (b_m1),
        .match2    (b_m2)
    );

    assign bus.A_READY = a_ready;
    assign bus.B_READY = b_ready;

    // Round-robin pick: on a tie the port that did not win last time goes.
    always_comb begin
        grant_a = a_ne && (!b_ne || (last == PORT_B));
        grant_b = b_ne && !grant_a;
    end

    // ---- stage p0: registered register-file write port ----
    // Address/data hold their last values when nothing is granted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p0  <= 1'b0;
            addr_p0 <= '0;
            data_p0 <= '0;
            last    <= PORT_B;
        end else begin
            vld_p0 <= grant_a || grant_b;
            if (grant_a) begin
                addr_p0 <= a_head_addr;
                data_p0 <= a_head_data;
                last    <= PORT_A;
            end else if (grant_b) begin
                addr_p0 <= b_head_addr;
                data_p0 <= b_head_data;
                last    <= PORT_B;
            end
        end
    end

    assign bus.WRITE     = vld_p0;
    assign bus.INADDRESS = addr_p0;
    assign bus.IN        = data_p0;

    // Queue contents are about to be discarded while reset is held, so mask hazards then.
    assign bus.HAZARD1 = !RESET && ((|a_m1) || (|b_m1) || (vld_p0 && (addr_p0 == bus.RD1ADDR)));
    assign bus.HAZARD2 = !RESET && ((|a_m2) || (|b_m2) || (vld_p0 && (addr_p0 == bus.RD2ADDR)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a round-robin scoreboard watches every
// cycle on the falling edge, a vector table exercises single writes and
// hazard flags, and directed sequences cover contention, backpressure,
// reset with full queues and same-address collisions.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int DEPTH = 2;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    regfile_write_arbiter_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic       port;
        logic [2:0] addr;
        logic [7:0] data;
        logic [2:0] rd1;
        logic [2:0] rd2;
        logic       h1;
        logic       h2;
    } vec_t;

    int        tests  = 0;
    int        errors = 0;
    wr_t       qa[$];
    wr_t       qb[$];
    wr_t       pend_a, pend_b;
    logic      pend_a_v = 1'b0;
    logic      pend_b_v = 1'b0;
    logic      rst_prev = 1'b1;
    port_sel_e last_m   = PORT_B;
    logic [2:0] held_addr = '0;
    logic [7:0] held_data = '0;
    vec_t      vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: check the write produced by the last edge, then commit the
    // transfers that edge accepted, then sample what the next edge will accept.
    always @(negedge CLK) begin
        wr_t       e;
        port_sel_e pick;
        if (rst_prev) begin
            check("write_after_reset", bus.WRITE, 0);
            check("inaddr_after_reset", bus.INADDRESS, 0);
            check("in_after_reset", $unsigned(bus.IN), 0);
            qa.delete();
            qb.delete();
            last_m    = PORT_B;
            held_addr = '0;
            held_data = '0;
        end else if (bus.WRITE) begin
            if (qa.size() == 0 && qb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                if (qa.size() != 0 && qb.size() != 0)
                    pick = (last_m == PORT_B) ? PORT_A : PORT_B;
                else
                    pick = (qa.size() != 0) ? PORT_A : PORT_B;
                if (pick == PORT_A) e = qa.pop_front();
                else                e = qb.pop_front();
                check("sb_addr", bus.INADDRESS, e.addr);
                check("sb_data", $unsigned(bus.IN), e.data);
                last_m    = pick;
                held_addr = e.addr;
                held_data = e.data;
            end
        end else begin
            check("idle_with_pending", qa.size() + qb.size(), 0);
            check("held_addr", bus.INADDRESS, held_addr);
            check("held_data", $unsigned(bus.IN), held_data);
        end
        if (pend_a_v) qa.push_back(pend_a);
        if (pend_b_v) qb.push_back(pend_b);
        check("a_ready", bus.A_READY, (!RESET && qa.size() < DEPTH));
        check("b_ready", bus.B_READY, (!RESET && qb.size() < DEPTH));
        pend_a_v = bus.A_VALID && bus.A_READY;
        pend_a   = {bus.A_ADDR, $unsigned(bus.A_DATA)};
        pend_b_v = bus.B_VALID && bus.B_READY;
        pend_b   = {bus.B_ADDR, $unsigned(bus.B_DATA)};
        rst_prev = RESET;
    end

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || bus.WRITE) && n < 30) begin
            step();
            n++;
        end
        check("drain_in_time", (n < 30), 1);
        repeat (2) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_full;
        vecs[0] = '{1'b0, 3'd3, 8'h2A, 3'd3, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 3'd5, 8'h80, 3'd5, 3'd6, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 3'd6, 8'hFF, 3'd5, 3'd6, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 3'd7, 8'h01, 3'd2, 3'd4, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 3'd0, 8'h7F, 3'd0, 3'd0, 1'b1, 1'b1};

        bus.A_VALID = 1'b0; bus.A_ADDR = '0; bus.A_DATA = '0;
        bus.B_VALID = 1'b0; bus.B_ADDR = '0; bus.B_DATA = '0;
        bus.RD1ADDR = '0;   bus.RD2ADDR = '0;

        // Reset: ready low while held, outputs and hazards clear afterwards
        repeat (2) step();
        check("a_ready_in_reset", bus.A_READY, 0);
        check("b_ready_in_reset", bus.B_READY, 0);
        check("hazard1_in_reset", bus.HAZARD1, 0);
        check("hazard2_in_reset", bus.HAZARD2, 0);
        RESET = 1'b0;
        step();
        #1;
        check("reset_write", bus.WRITE, 0);
        check("reset_inaddr", bus.INADDRESS, 0);
        check("reset_in", $unsigned(bus.IN), 0);
        check("reset_hazard1", bus.HAZARD1, 0);
        check("reset_hazard2", bus.HAZARD2, 0);

        // Table: single write, one cycle latency, hazards while pending and writing
        for (int i = 0; i < 5; i++) begin
            step();
            bus.RD1ADDR = vecs[i].rd1;
            bus.RD2ADDR = vecs[i].rd2;
            if (vecs[i].port == 1'b0) begin
                bus.A_VALID = 1'b1; bus.A_ADDR = vecs[i].addr; bus.A_DATA = vecs[i].data;
            end else begin
                bus.B_VALID = 1'b1; bus.B_ADDR = vecs[i].addr; bus.B_DATA = vecs[i].data;
            end
            #1;
            check("vec_ready", vecs[i].port ? bus.B_READY : bus.A_READY, 1);
            step();
            bus.A_VALID = 1'b0;
            bus.B_VALID = 1'b0;
            #1;
            check("vec_queued_nowrite", bus.WRITE, 0);
            check("vec_queued_h1", bus.HAZARD1, vecs[i].h1);
            check("vec_queued_h2", bus.HAZARD2, vecs[i].h2);
            step();
            #1;
            check("vec_write", bus.WRITE, 1);
            check("vec_inaddr", bus.INADDRESS, vecs[i].addr);
            check("vec_in", $unsigned(bus.IN), vecs[i].data);
            check("vec_write_h1", bus.HAZARD1, vecs[i].h1);
            check("vec_write_h2", bus.HAZARD2, vecs[i].h2);
            step();
            #1;
            check("vec_done_write", bus.WRITE, 0);
            check("vec_done_h1", bus.HAZARD1, 0);
            check("vec_done_h2", bus.HAZARD2, 0);
        end

        // Contention: both valid continuously, grants alternate starting with A
        step();
        saw_full = 1'b0;
        bus.A_VALID = 1'b1; bus.A_ADDR = 3'd1; bus.A_DATA = 8'd10;
        bus.B_VALID = 1'b1; bus.B_ADDR = 3'd2; bus.B_DATA = 8'd20;
        for (int j = 0; j < 8; j++) begin
            step();
            if (!bus.A_READY) saw_full = 1'b1;
            if (j >= 1) begin
                check("alt_write", bus.WRITE, 1);
                check("alt_grant_addr", bus.INADDRESS, (j % 2 == 1) ? 1 : 2);
            end
        end
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        check("a_ready_dropped_when_full", saw_full, 1);
        drain();

        // Fill both queues, pulse reset: nothing queued may ever be written
        step();
        bus.A_VALID = 1'b1; bus.A_ADDR = 3'd3; bus.A_DATA = 8'h33;
        bus.B_VALID = 1'b1; bus.B_ADDR = 3'd5; bus.B_DATA = 8'h55;
        repeat (4) step();
        RESET = 1'b1;
        #1;
        check("a_ready_mid_reset", bus.A_READY, 0);
        check("b_ready_mid_reset", bus.B_READY, 0);
        step();
        RESET = 1'b0;
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        #1;
        check("write_cleared_by_reset", bus.WRITE, 0);
        repeat (6) begin
            step();
            check("no_write_after_reset", bus.WRITE, 0);
        end

        // Same address at both heads: two writes, A then B after reset
        step();
        bus.A_VALID = 1'b1; bus.A_ADDR = 3'd4; bus.A_DATA = 8'hFF;
        bus.B_VALID = 1'b1; bus.B_ADDR = 3'd4; bus.B_DATA = 8'd7;
        step();
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        step();
        check("same_addr_first_addr", bus.INADDRESS, 4);
        check("same_addr_first_in", $unsigned(bus.IN), 8'hFF);
        step();
        check("same_addr_second_write", bus.WRITE, 1);
        check("same_addr_second_addr", bus.INADDRESS, 4);
        step();
        check("same_addr_idle", bus.WRITE, 0);
        check("same_addr_final_in", $unsigned(bus.IN), 8'd7);

        drain();
        check("queues_empty_at_end", qa.size() + qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH, 2, entries per requester queue (power of two, 2..8)
  DATA_W, 8, register data width
  ADDR_W, 3, register address width (8 registers)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CLK  input  1  clock; all state updates on posedge
  RESET  input  1  reset, synchronous, active-high
  A_VALID  input  1  requester A (ALU writeback) has a write
  A_READY  output  1  A queue can accept
  A_ADDR  input  ADDR_W  A destination register
  A_DATA  input  DATA_W  A write data, signed
  B_VALID  input  1  requester B (memory load) has a write
  B_READY  output  1  B queue can accept
  B_ADDR  input  ADDR_W  B destination register
  B_DATA  input  DATA_W  B write data, signed
  WRITE  output  1  register-file write enable
  INADDRESS  output  ADDR_W  register-file write address
  IN  output  DATA_W  register-file write data
  RD1ADDR  input  ADDR_W  register-file read port 1 address
  RD2ADDR  input  ADDR_W  register-file read port 2 address
  HAZARD1  output  1  pending write targets RD1ADDR
  HAZARD2  output  1  pending write targets RD2ADDR

Function
REQ-003 A transfer on port X SHALL occur at a posedge where X_VALID and X_READY are both 1; the entry is pushed into X's FIFO.
REQ-004 X_READY SHALL be 1 exactly when X's FIFO holds fewer than DEPTH entries and RESET is 0; combinational from occupancy only, never from X_VALID.
REQ-005 Push and pop on the same FIFO in one cycle SHALL both take effect; occupancy unchanged.
REQ-006 Each posedge with at least one FIFO non-empty, the arbiter SHALL pop exactly one head and register it onto WRITE=1, INADDRESS, IN for the following cycle.
REQ-007 With no non-empty FIFO, WRITE SHALL be 0 next cycle; INADDRESS and IN SHALL hold last values.
REQ-008 Arbitration SHALL be round-robin: LAST pointer records last-granted port; when both heads valid, the port not equal to LAST wins; single valid head wins unconditionally; LAST updates only on a grant.
REQ-009 Latency: an entry accepted at edge N into an empty FIFO with no competing head SHALL appear with WRITE=1 during cycle N+1 to N+2 (popped at edge N+1).
REQ-010 Order within one port SHALL be preserved; no ordering guarantee across ports.
REQ-011 Same address at both heads SHALL be written twice, in grant order; no merging.
REQ-012 HAZARD1 SHALL be 1, combinationally, when any valid FIFO entry of either port, or the registered output while WRITE=1, has address equal to RD1ADDR; HAZARD2 likewise for RD2ADDR.
REQ-013 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width SHALL be log2(DEPTH)+1 bits.
REQ-014 A_DATA/B_DATA SHALL pass to IN unmodified, no sign extension or arithmetic.

Reset
REQ-015 With RESET=1 at a posedge: both FIFOs empty, pointers 0, LAST=B (so A wins first tie), WRITE=0, INADDRESS=0, IN=0.
REQ-016 While RESET=1, A_READY=B_READY=0 and no push or pop SHALL occur; pending entries mid-operation SHALL be discarded.
REQ-017 HAZARD1/HAZARD2 SHALL be 0 during and after reset until an entry is accepted.

Structure
REQ-018 Package regfile_arb_pkg SHALL hold ADDR_W, DATA_W, NREG=8 and the port-select enum {PORT_A, PORT_B}.
REQ-019 One sub-module wb_fifo (DEPTH-entry queue with address-match vector output) SHALL be instantiated twice.
REQ-020 WRITE, INADDRESS, IN SHALL be registered outputs; READY and HAZARD combinational.

Verification
REQ-021 Reset then A writes (addr 3, data 8'h2A) once -> WRITE=1, INADDRESS=3, IN=8'h2A exactly one cycle, starting one cycle after acceptance.
REQ-022 A and B both valid continuously, A addr 1 data 10, B addr 2 data 20 -> grants alternate A,B,A,B; first grant A.
REQ-023 A valid 3 cycles with no pops possible (B saturating, DEPTH=2) -> A_READY drops to 0 at occupancy 2, rises after A pop; no entry lost or duplicated.
REQ-024 A pending addr 5, RD1ADDR=5, RD2ADDR=6 -> HAZARD1=1, HAZARD2=0 until write cycle ends, then HAZARD1=0.
REQ-025 Fill both FIFOs, assert RESET one cycle -> WRITE=0 next cycle, READY=0 during reset, no queued entry ever written afterwards.
REQ-026 Both heads addr 4, A data -1, B data 7 -> two writes to 4, final IN value matches later grant per round-robin.
